// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Owns the single register file write port and arbitrates it between the
//   pipeline writeback stage and the multiply/divide unit. Writeback always
//   wins; the MD result waits (md_ready low) and, once it has waited
//   STARVE_LIMIT cycles, starve_stall asks the pipeline for a writeback bubble.
//   A pending scoreboard tracks registers with an MD result still outstanding
//   and drives hazard_stall for the decode stage.
//
// Parameters
//   STARVE_LIMIT   waiting cycles before starve_stall asserts (1..15)
//
// Ports
//   clk            clock, all state on rising edge
//   rst            asynchronous active-low reset
//   wb_we/wb_addr/wb_data            writeback stage write request
//   md_issue/md_issue_addr           MD op issued, marks destination pending
//   md_valid/md_addr/md_data         MD completed result
//   md_ready       MD result accepted this cycle (combinational)
//   rd_a1/rd_a2    decode-stage source registers
//   WE3/A3/WD3     registered register file write port
//   hazard_stall   decode reads a register with an MD result outstanding
//   starve_stall   registered request for a writeback bubble

module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_addr,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic [4:0]  rd_a1,
    input  logic [4:0]  rd_a2,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        hazard_stall,
    output logic        starve_stall
);

    localparam logic [3:0] STARVE_MAX = 4'hF;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    logic        handshake;
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_cnt_nxt;

    // Writeback has unconditional priority so it can never be dropped.
    assign md_ready  = md_valid & ~wb_we;
    assign handshake = md_valid & md_ready;

    assign hazard_stall = ((rd_a1 != 5'd0) & pending[rd_a1]) |
                          ((rd_a2 != 5'd0) & pending[rd_a2]);

    // Clear before set: an issue and a completion to the same register on
    // the same edge leave the bit set, since the issue is the newer op.
    always_comb begin
        pending_nxt = pending;
        if (handshake) begin
            pending_nxt[md_addr] = 1'b0;
        end
        if (md_issue) begin
            pending_nxt[md_issue_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!md_valid || handshake) begin
            starve_cnt_nxt = 4'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    // Register 0 is hardwired: the write is consumed but never enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WE3 <= 1'b0;
            A3  <= 5'd0;
            WD3 <= 32'd0;
        end else if (wb_we) begin
            WE3 <= (wb_addr != 5'd0);
            A3  <= wb_addr;
            WD3 <= wb_data;
        end else if (handshake) begin
            WE3 <= (md_addr != 5'd0);
            A3  <= md_addr;
            WD3 <= md_data;
        end else begin
            WE3 <= 1'b0;
        end
    end

    // starve_stall follows the updated count so it drops right after the
    // handshake edge rather than one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending      <= 32'd0;
            starve_cnt   <= 4'd0;
            starve_stall <= 1'b0;
        end else begin
            pending      <= pending_nxt;
            starve_cnt   <= starve_cnt_nxt;
            starve_stall <= (starve_cnt_nxt >= LIMIT);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_issue;
    logic [4:0]  md_issue_addr;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        hazard_stall;
    logic        starve_stall;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .md_issue      (md_issue),
        .md_issue_addr (md_issue_addr),
        .md_valid      (md_valid),
        .md_addr       (md_addr),
        .md_data       (md_data),
        .md_ready      (md_ready),
        .rd_a1         (rd_a1),
        .rd_a2         (rd_a2),
        .WE3           (WE3),
        .A3            (A3),
        .WD3           (WD3),
        .hazard_stall  (hazard_stall),
        .starve_stall  (starve_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic        starve;
    } exp_t;

    exp_t sbq[$];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pend;
    int          m_cnt;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 32'd0;
        m_cnt  = 0;
        m_a3   = 5'd0;
        m_wd3  = 32'd0;
    endtask

    function automatic logic m_hazard(input logic [4:0] r1, input logic [4:0] r2);
        return (r1 != 0 && m_pend[r1]) || (r2 != 0 && m_pend[r2]);
    endfunction

    // Inputs are already driven (mid-cycle). Checks combinational outputs,
    // pushes the expected registered outcome, clocks, then pops and compares.
    task automatic step();
        logic ready_e;
        logic hs;
        exp_t e;
        exp_t got;
        #1;
        ready_e = md_valid & ~wb_we;
        chk("md_ready", {31'd0, md_ready}, {31'd0, ready_e});
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, m_hazard(rd_a1, rd_a2)});
        hs = md_valid & ready_e;
        e.we = 1'b0;
        if (wb_we) begin
            e.we = (wb_addr != 0); m_a3 = wb_addr; m_wd3 = wb_data;
        end else if (hs) begin
            e.we = (md_addr != 0); m_a3 = md_addr; m_wd3 = md_data;
        end
        e.a = m_a3;
        e.d = m_wd3;
        if (hs && md_addr != 0) m_pend[md_addr] = 1'b0;
        if (md_issue && md_issue_addr != 0) m_pend[md_issue_addr] = 1'b1;
        if (!md_valid || hs) m_cnt = 0;
        else if (m_cnt < 15) m_cnt++;
        e.starve = (m_cnt >= LIMIT);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sbq.pop_front();
            chk("WE3", {31'd0, WE3}, {31'd0, got.we});
            chk("A3", {27'd0, A3}, {27'd0, got.a});
            chk("WD3", WD3, got.d);
            chk("starve_stall", {31'd0, starve_stall}, {31'd0, got.starve});
        end
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_addr = 0; wb_data = 0;
        md_issue = 0; md_issue_addr = 0;
        md_valid = 0; md_addr = 0; md_data = 0;
        rd_a1 = 0; rd_a2 = 0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        chk("rst_WE3", {31'd0, WE3}, 32'd0);
        chk("rst_A3", {27'd0, A3}, 32'd0);
        chk("rst_WD3", WD3, 32'd0);
        chk("rst_starve", {31'd0, starve_stall}, 32'd0);
        chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // single sources
        wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; step();
        idle_inputs(); step();
        md_valid = 1; md_addr = 9; md_data = 32'h0000_1234; step();

        // collision: writeback first, MD one cycle later
        wb_we = 1; wb_addr = 3; wb_data = 32'hAAAA_0003;
        md_valid = 1; md_addr = 7; md_data = 32'h7777_7777; step();
        wb_we = 0; step();
        idle_inputs(); step();

        // scoreboard hazard on r8
        md_issue = 1; md_issue_addr = 8; step();
        md_issue = 0; rd_a1 = 8; step(); step();
        md_valid = 1; md_addr = 8; md_data = 32'h0000_0088; step();
        md_valid = 0; step();
        rd_a1 = 0;

        // starvation with saturation, then release
        md_valid = 1; md_addr = 10; md_data = 32'h1010_1010;
        for (int i = 0; i < 18; i++) begin
            wb_we = 1; wb_addr = 5'((i % 30) + 1); wb_data = $urandom; step();
        end
        wb_we = 0; step();
        md_valid = 0; step();

        // register 0 from either source
        md_valid = 1; md_addr = 0; md_data = 32'h0000_00FF; step();
        md_valid = 0; wb_we = 1; wb_addr = 0; wb_data = 32'h1111_0000; step();
        idle_inputs(); step();

        // same-edge issue and completion on r12
        md_issue = 1; md_issue_addr = 12; step();
        md_valid = 1; md_addr = 12; md_data = 32'h0000_0C0C; step();
        idle_inputs(); rd_a2 = 12; step();
        md_valid = 1; md_addr = 12; md_data = 32'h0000_0C0D; step();
        idle_inputs(); rd_a2 = 12; step();

        // randomized traffic over a small register window
        for (int i = 0; i < 60; i++) begin
            wb_we         = ($urandom_range(0, 2) == 0);
            wb_addr       = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            md_issue      = ($urandom_range(0, 2) == 0);
            md_issue_addr = 5'($urandom_range(0, 7));
            md_valid      = ($urandom_range(0, 1) == 0);
            md_addr       = 5'($urandom_range(0, 7));
            md_data       = $urandom;
            rd_a1         = 5'($urandom_range(0, 7));
            rd_a2         = 5'($urandom_range(0, 7));
            step();
        end
        idle_inputs(); step();

        // reset mid-operation with a write to r4 in flight
        md_issue = 1; md_issue_addr = 4; step();
        md_issue = 0; wb_we = 1; wb_addr = 4; wb_data = 32'h4444_4444; step();
        wb_we = 0; rd_a1 = 4; md_valid = 1; md_addr = 4; md_data = 32'h0;
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_WE3", {31'd0, WE3}, 32'd0);
        chk("mid_rst_A3", {27'd0, A3}, 32'd0);
        chk("mid_rst_WD3", WD3, 32'd0);
        chk("mid_rst_starve", {31'd0, starve_stall}, 32'd0);
        chk("mid_rst_hazard", {31'd0, hazard_stall}, 32'd0);
        chk("mid_rst_md_ready", {31'd0, md_ready}, 32'd1);
        sbq.delete();
        model_reset();
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        wb_we = 1; wb_addr = 6; wb_data = 32'h6666_0006; step();
        idle_inputs(); step();

        if (sbq.size() != 0) chk("scoreboard_drain", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive cycles the MD result may wait before starve_stall is asserted (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 wb_we  input  1  pipeline writeback stage requests a register write this cycle.
REQ-005 wb_addr  input  5  writeback destination register.
REQ-006 wb_data  input  32  writeback data.
REQ-007 md_issue  input  1  multiply/divide operation issued this cycle; marks its destination pending.
REQ-008 md_issue_addr  input  5  destination register of the issued MD operation.
REQ-009 md_valid  input  1  MD unit presents a completed result.
REQ-010 md_addr  input  5  MD result destination register.
REQ-011 md_data  input  32  MD result data.
REQ-012 md_ready  output  1  arbiter accepts the MD result this cycle.
REQ-013 rd_a1, rd_a2  input  5 each  decode-stage source register numbers.
REQ-014 WE3  output  1  register file write enable.
REQ-015 A3  output  5  register file write address.
REQ-016 WD3  output  32  register file write data.
REQ-017 hazard_stall  output  1  decode reads a register with an MD result still outstanding.
REQ-018 starve_stall  output  1  request to the pipeline to insert a writeback bubble so the MD result can drain.

Function
REQ-019 The block shall own the single register file write port; WE3/A3/WD3 shall be registered, with exactly 1 cycle from winning arbitration to appearing at the outputs.
REQ-020 Priority: wb_we=1 shall always win; md_ready = md_valid & ~wb_we (combinational), so a writeback is never dropped.
REQ-021 MD handshake completes on an edge where md_valid=1 and md_ready=1; the next cycle shall then drive WE3=1, A3=md_addr, WD3=md_data.
REQ-022 With neither wb_we nor md_valid asserted, the next cycle shall drive WE3=0; A3/WD3 hold their previous values.
REQ-023 A write to register 0 (from either source) shall produce WE3=0 in the output cycle; an MD handshake to register 0 still completes.
REQ-024 Scoreboard: 32-bit pending vector; bit 0 is constant 0; md_issue with md_issue_addr!=0 shall set pending[md_issue_addr] at the edge.
REQ-025 An MD handshake shall clear pending[md_addr] at the same edge that registers the write.
REQ-026 When an issue and a completion hit the same register on the same edge, set shall win (the bit stays 1).
REQ-027 md_issue to an already-pending register shall leave the bit set; the first completion clears it (the pipeline guarantees one outstanding MD op per register).
REQ-028 hazard_stall = (rd_a1!=0 & pending[rd_a1]) | (rd_a2!=0 & pending[rd_a2]), combinational from current state; bypass in the register file covers the cycle after clear.
REQ-029 Starvation counter (4 bits): increments each cycle md_valid=1 & md_ready=0, saturating at 15; clears to 0 on handshake or when md_valid=0.
REQ-030 starve_stall shall be registered, 1 while counter >= STARVE_LIMIT; the pipeline deasserts wb_we while starve_stall=1. If wb_we is still 1, WB still wins and no data is lost.
REQ-031 starve_stall shall drop the cycle after the MD handshake.

Reset
REQ-032 rst=0 shall immediately and asynchronously force WE3=0, A3=0, WD3=0, starve_stall=0, pending=0 and starvation counter=0.
REQ-033 With rst=0: hazard_stall=0 (pending cleared); md_ready still follows REQ-020.
REQ-034 Reset asserted mid-operation shall discard any accepted-but-unwritten result and all pending bits; first write possible on the first edge after rst rises.
REQ-035 Reset release shall be synchronised externally; the block has no reset synchroniser.

Verification
REQ-036 Single sources: wb_we=1, addr 5, data 0xDEADBEEF -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; md_valid alone, addr 9 -> md_ready=1 and next cycle A3=9.
REQ-037 Collision: wb_we=1 (addr 3) and md_valid=1 (addr 7) in the same cycle -> md_ready=0, WB write first; next idle cycle MD is accepted -> A3=7 one cycle later.
REQ-038 Scoreboard: issue to r8, then rd_a1=8 -> hazard_stall=1 until the MD handshake for r8; the edge after the handshake -> hazard_stall=0, WE3=1, A3=8.
REQ-039 Starvation: STARVE_LIMIT=4, wb_we=1 continuously with md_valid=1 -> starve_stall=1 after 4 waiting cycles; bench drops wb_we -> handshake, starve_stall=0 the next cycle.
REQ-040 Register 0 and same-edge events: MD result to r0 -> handshake with WE3=0; issue and complete r12 on the same edge -> pending[12] stays 1.
REQ-041 Reset mid-operation: pending r4 with WE3=1 in flight, assert rst=0 between edges -> outputs 0 immediately and hazard_stall=0 for rd_a1=4.
